// File: rtl/prio_irq_ctrl.sv
// prio_irq_ctrl
// Priority interrupt controller. Requests are organised as N_GRP groups of
// N_CH channels, and the flat request index is g*N_CH+c. Requests are captured
// into a pending register. In level mode the register follows req. In edge
// mode a rising edge sets a pending bit, and the bit stays set until its
// interrupt is accepted or clr_all is asserted. Eligible requests are pending
// and enabled. The lowest eligible group wins. Within that group, the highest
// eligible channel wins. The winner is presented with a valid/ready handshake.
//
// Ports
//   clk        single clock, rising edge
//   rst_n      asynchronous active-low reset
//   en         per-channel enable, shared by all groups
//   req        flat request vector, index g*N_CH+c
//   clr_all    synchronous clear of all pending bits and any presented irq
//   irq_ready  consumer accepts the presented interrupt
//   irq_valid  an interrupt is presented
//   irq_grp    group of the presented interrupt
//   irq_chan   channel of the presented interrupt
//   grp_pend   per-group registered "any enabled pending" flag

module prio_irq_ctrl #(
    parameter int N_CH  = 9,
    parameter int N_GRP = 3,
    parameter int EDGE  = 0,
    parameter int CW    = $clog2(N_CH),
    parameter int GW    = (N_GRP > 1) ? $clog2(N_GRP) : 1
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [N_CH-1:0]        en,
    input  logic [N_GRP*N_CH-1:0]  req,
    input  logic                   clr_all,
    input  logic                   irq_ready,
    output logic                   irq_valid,
    output logic [GW-1:0]          irq_grp,
    output logic [CW-1:0]          irq_chan,
    output logic [N_GRP-1:0]       grp_pend
);

    localparam int NB = N_GRP * N_CH;

    typedef enum logic [1:0] {
        IDLE,
        PRESENT,
        RETIRE
    } state_t;

    state_t            state;
    logic [NB-1:0]     pend;
    logic [NB-1:0]     req_q;
    logic [NB-1:0]     en_all;
    logic [NB-1:0]     elig;
    logic [NB-1:0]     acc_mask;
    logic [NB-1:0]     pend_nxt;
    logic [N_GRP-1:0]  grp_or;
    logic              found;
    logic [GW-1:0]     win_grp;
    logic [CW-1:0]     win_chan;
    logic              accept;

    assign accept = (state == PRESENT) && irq_valid && irq_ready;

    // The channel enables apply equally to every group. The enable is
    // replicated across the groups, and the per-group OR is formed here.
    always_comb begin
        en_all = '0;
        grp_or = '0;
        for (int g = 0; g < N_GRP; g++) begin
            en_all[g*N_CH +: N_CH] = en;
        end
        elig = pend & en_all;
        for (int g = 0; g < N_GRP; g++) begin
            grp_or[g] = |elig[g*N_CH +: N_CH];
        end
    end

    // Fixed-priority arbiter. The scan runs from the highest group down to
    // the lowest. Within each group it runs from channel 0 up. Each eligible
    // bit overwrites the previous candidate. The last bit written is
    // therefore the highest channel of the lowest eligible group.
    always_comb begin
        found    = 1'b0;
        win_grp  = '0;
        win_chan = '0;
        for (int g = N_GRP - 1; g >= 0; g--) begin
            for (int c = 0; c < N_CH; c++) begin
                if (elig[g*N_CH + c]) begin
                    found    = 1'b1;
                    win_grp  = GW'(g);
                    win_chan = CW'(c);
                end
            end
        end
    end

    // This mask holds the one-hot pending bit of the interrupt being
    // accepted. It is all zeros in every cycle without an acceptance.
    always_comb begin
        acc_mask = '0;
        for (int g = 0; g < N_GRP; g++) begin
            for (int c = 0; c < N_CH; c++) begin
                acc_mask[g*N_CH + c] = accept && (irq_grp == GW'(g)) &&
                                       (irq_chan == CW'(c));
            end
        end
    end

    // Next pending value. In edge mode the edge term is ORed in after the
    // acceptance clear. A fresh edge on the bit being accepted therefore
    // survives. clr_all overrides everything. The edge history register
    // is still updated during a clear, so no edge is replayed afterwards.
    always_comb begin
        if (EDGE == 0) begin
            pend_nxt = req;
        end else begin
            pend_nxt = (pend & ~acc_mask) | (req & ~req_q);
        end
        if (clr_all) begin
            pend_nxt = '0;
        end
    end

    // The capture registers and the presentation FSM. In IDLE, irq_ready
    // is ignored. Once an interrupt is latched in PRESENT, it stays fixed
    // until the handshake completes. RETIRE is a single bubble cycle. Its
    // purpose is to let a level-mode source be resampled before it is
    // presented again.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            pend      <= '0;
            req_q     <= '0;
            grp_pend  <= '0;
            irq_valid <= 1'b0;
            irq_grp   <= '0;
            irq_chan  <= '0;
        end else begin
            req_q    <= req;
            pend     <= pend_nxt;
            grp_pend <= grp_or;
            if (clr_all) begin
                state     <= IDLE;
                irq_valid <= 1'b0;
            end else begin
                case (state)
                    IDLE: begin
                        if (found) begin
                            irq_grp   <= win_grp;
                            irq_chan  <= win_chan;
                            irq_valid <= 1'b1;
                            state     <= PRESENT;
                        end
                    end
                    PRESENT: begin
                        if (irq_ready) begin
                            irq_valid <= 1'b0;
                            state     <= RETIRE;
                        end
                    end
                    RETIRE: begin
                        state <= IDLE;
                    end
                    default: begin
                        irq_valid <= 1'b0;
                        state     <= IDLE;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_prio_irq_ctrl.sv
// tb_prio_irq_ctrl
// Directed bench for prio_irq_ctrl with default sizing (9 channels x 3 groups).
// The bench builds one edge-mode instance and one level-mode instance. Both
// share the same stimulus, and each section checks only the instance it is
// exercising.

module tb_prio_irq_ctrl;

    localparam int N_CH  = 9;
    localparam int N_GRP = 3;
    localparam int NB    = N_CH * N_GRP;

    logic           clk = 1'b0;
    logic           rst_n;
    logic [8:0]     en;
    logic [NB-1:0]  req;
    logic           clr_all;
    logic           irq_ready;

    logic           e_valid;
    logic [1:0]     e_grp;
    logic [3:0]     e_chan;
    logic [2:0]     e_gp;
    logic           l_valid;
    logic [1:0]     l_grp;
    logic [3:0]     l_chan;
    logic [2:0]     l_gp;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    prio_irq_ctrl #(.N_CH(N_CH), .N_GRP(N_GRP), .EDGE(1)) dut_edge (
        .clk(clk), .rst_n(rst_n), .en(en), .req(req), .clr_all(clr_all),
        .irq_ready(irq_ready), .irq_valid(e_valid), .irq_grp(e_grp),
        .irq_chan(e_chan), .grp_pend(e_gp)
    );

    prio_irq_ctrl #(.N_CH(N_CH), .N_GRP(N_GRP), .EDGE(0)) dut_lvl (
        .clk(clk), .rst_n(rst_n), .en(en), .req(req), .clr_all(clr_all),
        .irq_ready(irq_ready), .irq_valid(l_valid), .irq_grp(l_grp),
        .irq_chan(l_chan), .grp_pend(l_gp)
    );

    typedef struct {
        logic [NB-1:0] req;
        logic          rdy;
        logic          v;
        logic [1:0]    g;
        logic [3:0]    c;
        logic [2:0]    gp;
    } vec_t;

    vec_t tbl[23];

    function automatic logic [NB-1:0] bit_of(input int i);
        logic [NB-1:0] r;
        r = '0;
        r[i] = 1'b1;
        return r;
    endfunction

    // Drive the inputs at the falling edge, let the rising edge sample them,
    // then settle 1 time unit past that edge before anything is compared.
    task automatic applyStimulus(input logic [NB-1:0] r, input logic [8:0] e,
                                 input logic c, input logic rdy);
        @(negedge clk);
        req       = r;
        en        = e;
        clr_all   = c;
        irq_ready = rdy;
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string name, input bit lvl, input logic v,
                               input logic [1:0] g, input logic [3:0] ch,
                               input logic [2:0] gp);
        logic       av;
        logic [1:0] ag;
        logic [3:0] ac;
        logic [2:0] agp;
        av  = lvl ? l_valid : e_valid;
        ag  = lvl ? l_grp   : e_grp;
        ac  = lvl ? l_chan  : e_chan;
        agp = lvl ? l_gp    : e_gp;
        n_cmp += 4;
        if (av !== v) begin
            n_bad++;
            $display("[TB] FAIL %s valid: got %0b want %0b", name, av, v);
        end
        if (ag !== g) begin
            n_bad++;
            $display("[TB] FAIL %s grp: got %0d want %0d", name, ag, g);
        end
        if (ac !== ch) begin
            n_bad++;
            $display("[TB] FAIL %s chan: got %0d want %0d", name, ac, ch);
        end
        if (agp !== gp) begin
            n_bad++;
            $display("[TB] FAIL %s grp_pend: got %b want %b", name, agp, gp);
        end
    endtask

    task automatic step(input string name, input logic [NB-1:0] r,
                        input logic [8:0] e, input logic c, input logic rdy,
                        input bit lvl, input logic v, input logic [1:0] g,
                        input logic [3:0] ch, input logic [2:0] gp);
        applyStimulus(r, e, c, rdy);
        checkOutput(name, lvl, v, g, ch, gp);
    endtask

    task automatic doReset();
        @(negedge clk);
        req       = '0;
        clr_all   = 1'b0;
        irq_ready = 1'b0;
        en        = 9'h1FF;
        rst_n     = 1'b0;
        @(negedge clk);
        checkOutput("rst_edge", 1'b0, 1'b0, 2'd0, 4'd0, 3'b000);
        checkOutput("rst_lvl",  1'b1, 1'b0, 2'd0, 4'd0, 3'b000);
        rst_n = 1'b1;
    endtask

    initial begin
        logic [NB-1:0] m3;
        m3 = bit_of(20) | bit_of(13) | bit_of(10);

        // Single pulse on channel 4 of group 0, then accepted after a few cycles.
        tbl[0]  = '{bit_of(4),  1'b0, 1'b0, 2'd0, 4'd0, 3'b000};
        tbl[1]  = '{'0,         1'b0, 1'b1, 2'd0, 4'd4, 3'b001};
        tbl[2]  = '{'0,         1'b0, 1'b1, 2'd0, 4'd4, 3'b001};
        tbl[3]  = '{'0,         1'b0, 1'b1, 2'd0, 4'd4, 3'b001};
        tbl[4]  = '{'0,         1'b0, 1'b1, 2'd0, 4'd4, 3'b001};
        tbl[5]  = '{'0,         1'b1, 1'b0, 2'd0, 4'd4, 3'b001};
        tbl[6]  = '{'0,         1'b0, 1'b0, 2'd0, 4'd4, 3'b000};
        tbl[7]  = '{'0,         1'b0, 1'b0, 2'd0, 4'd4, 3'b000};
        // Three simultaneous requests: (2,2), (1,4) and (1,1).
        // (2,8) then arrives while (2,2) is being presented.
        tbl[8]  = '{m3,         1'b0, 1'b0, 2'd0, 4'd4, 3'b000};
        tbl[9]  = '{m3,         1'b0, 1'b1, 2'd1, 4'd4, 3'b110};
        tbl[10] = '{'0,         1'b0, 1'b1, 2'd1, 4'd4, 3'b110};
        tbl[11] = '{'0,         1'b1, 1'b0, 2'd1, 4'd4, 3'b110};
        tbl[12] = '{'0,         1'b0, 1'b0, 2'd1, 4'd4, 3'b110};
        tbl[13] = '{'0,         1'b0, 1'b1, 2'd1, 4'd1, 3'b110};
        tbl[14] = '{'0,         1'b1, 1'b0, 2'd1, 4'd1, 3'b110};
        tbl[15] = '{'0,         1'b0, 1'b0, 2'd1, 4'd1, 3'b100};
        tbl[16] = '{'0,         1'b0, 1'b1, 2'd2, 4'd2, 3'b100};
        tbl[17] = '{bit_of(26), 1'b0, 1'b1, 2'd2, 4'd2, 3'b100};
        tbl[18] = '{'0,         1'b1, 1'b0, 2'd2, 4'd2, 3'b100};
        tbl[19] = '{'0,         1'b0, 1'b0, 2'd2, 4'd2, 3'b100};
        tbl[20] = '{'0,         1'b0, 1'b1, 2'd2, 4'd8, 3'b100};
        tbl[21] = '{'0,         1'b1, 1'b0, 2'd2, 4'd8, 3'b100};
        tbl[22] = '{'0,         1'b0, 1'b0, 2'd2, 4'd8, 3'b000};

        rst_n     = 1'b0;
        req       = '0;
        en        = 9'h1FF;
        clr_all   = 1'b0;
        irq_ready = 1'b0;
        repeat (2) @(negedge clk);
        checkOutput("init_edge", 1'b0, 1'b0, 2'd0, 4'd0, 3'b000);
        checkOutput("init_lvl",  1'b1, 1'b0, 2'd0, 4'd0, 3'b000);
        rst_n = 1'b1;

        for (int i = 0; i < 23; i++) begin
            applyStimulus(tbl[i].req, 9'h1FF, 1'b0, tbl[i].rdy);
            checkOutput($sformatf("tbl%0d", i), 1'b0, tbl[i].v, tbl[i].g,
                        tbl[i].c, tbl[i].gp);
        end

        // A new edge and an acceptance land on the same bit in one cycle.
        // The new edge must survive, and the interrupt is presented again.
        step("same1", bit_of(3), 9'h1FF, 0, 0, 0, 0, 2'd2, 4'd8, 3'b000);
        step("same2", '0,        9'h1FF, 0, 0, 0, 1, 2'd0, 4'd3, 3'b001);
        step("same3", bit_of(3), 9'h1FF, 0, 1, 0, 0, 2'd0, 4'd3, 3'b001);
        step("same4", '0,        9'h1FF, 0, 0, 0, 0, 2'd0, 4'd3, 3'b001);
        step("same5", '0,        9'h1FF, 0, 0, 0, 1, 2'd0, 4'd3, 3'b001);
        step("same6", '0,        9'h1FF, 0, 1, 0, 0, 2'd0, 4'd3, 3'b001);
        step("same7", '0,        9'h1FF, 0, 0, 0, 0, 2'd0, 4'd3, 3'b000);

        // A disabled channel stays pending and is served once it is enabled.
        step("mask1", bit_of(5), 9'h1DF, 0, 0, 0, 0, 2'd0, 4'd3, 3'b000);
        step("mask2", '0,        9'h1DF, 0, 0, 0, 0, 2'd0, 4'd3, 3'b000);
        step("mask3", '0,        9'h1DF, 0, 0, 0, 0, 2'd0, 4'd3, 3'b000);
        step("mask4", '0,        9'h1FF, 0, 0, 0, 1, 2'd0, 4'd5, 3'b001);
        step("mask5", '0,        9'h1FF, 0, 1, 0, 0, 2'd0, 4'd5, 3'b001);
        step("mask6", '0,        9'h1FF, 0, 0, 0, 0, 2'd0, 4'd5, 3'b000);

        // In edge mode, clr_all beats acceptance and a new edge in the same
        // cycle. A request that stays high afterwards is not counted again.
        step("clr1", bit_of(7), 9'h1FF, 0, 0, 0, 0, 2'd0, 4'd5, 3'b000);
        step("clr2", '0,        9'h1FF, 0, 0, 0, 1, 2'd0, 4'd7, 3'b001);
        step("clr3", bit_of(1), 9'h1FF, 1, 1, 0, 0, 2'd0, 4'd7, 3'b001);
        step("clr4", bit_of(1), 9'h1FF, 0, 0, 0, 0, 2'd0, 4'd7, 3'b000);
        step("clr5", bit_of(1), 9'h1FF, 0, 0, 0, 0, 2'd0, 4'd7, 3'b000);
        step("clr6", '0,        9'h1FF, 0, 0, 0, 0, 2'd0, 4'd7, 3'b000);

        doReset();

        // Level mode: channel 8 is held high and ready stays high. The
        // interrupt should repeat every 3 cycles. clr_all should then force
        // a gap of 2 cycles before the next presentation.
        step("lvl1",  bit_of(8), 9'h1FF, 0, 1, 1, 0, 2'd0, 4'd0, 3'b000);
        step("lvl2",  bit_of(8), 9'h1FF, 0, 1, 1, 1, 2'd0, 4'd8, 3'b001);
        step("lvl3",  bit_of(8), 9'h1FF, 0, 1, 1, 0, 2'd0, 4'd8, 3'b001);
        step("lvl4",  bit_of(8), 9'h1FF, 0, 1, 1, 0, 2'd0, 4'd8, 3'b001);
        step("lvl5",  bit_of(8), 9'h1FF, 0, 1, 1, 1, 2'd0, 4'd8, 3'b001);
        step("lvl6",  bit_of(8), 9'h1FF, 0, 1, 1, 0, 2'd0, 4'd8, 3'b001);
        step("lvl7",  bit_of(8), 9'h1FF, 0, 1, 1, 0, 2'd0, 4'd8, 3'b001);
        step("lvl8",  bit_of(8), 9'h1FF, 0, 0, 1, 1, 2'd0, 4'd8, 3'b001);
        step("lvl9",  bit_of(8), 9'h1FF, 1, 0, 1, 0, 2'd0, 4'd8, 3'b001);
        step("lvl10", bit_of(8), 9'h1FF, 0, 1, 1, 0, 2'd0, 4'd8, 3'b000);
        step("lvl11", bit_of(8), 9'h1FF, 0, 1, 1, 1, 2'd0, 4'd8, 3'b001);
        step("lvl12", '0,        9'h1FF, 0, 1, 1, 0, 2'd0, 4'd8, 3'b001);
        step("lvl13", '0,        9'h1FF, 0, 0, 1, 0, 2'd0, 4'd8, 3'b000);

        // Edge mode: reset is applied during PRESENT and must act without a
        // clock. Request 0 is held high while reset is released, so it counts
        // as a fresh edge.
        step("arst1", bit_of(0), 9'h1FF, 0, 0, 0, 0, 2'd0, 4'd8, 3'b000);
        step("arst2", bit_of(0), 9'h1FF, 0, 0, 0, 1, 2'd0, 4'd0, 3'b001);
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("arst_async", 1'b0, 1'b0, 2'd0, 4'd0, 3'b000);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        checkOutput("arst_edge1", 1'b0, 1'b0, 2'd0, 4'd0, 3'b000);
        step("arst_edge2", bit_of(0), 9'h1FF, 0, 0, 0, 1, 2'd0, 4'd0, 3'b001);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/prio_irq_ctrl.md
PRIO_IRQ_CTRL -- requirements
Module: prio_irq_ctrl

Interface
REQ-001 The block SHALL expose these parameters, one per line: name, default, meaning.
- N_CH, 9, channels per priority group (2..32)
- N_GRP, 3, priority groups (1..8)
- EDGE, 0, request capture mode (0 = level, 1 = rising edge)
- CW, clog2(N_CH), channel-index width
- GW, max(1, clog2(N_GRP)), group-index width
REQ-002 The block SHALL have these ports, one per line: name, direction, width, meaning.
- clk, in, 1, single clock, rising edge
- rst_n, in, 1, asynchronous active-low reset
- en, in, N_CH, per-channel enable shared by all groups
- req, in, N_GRP*N_CH, requests; flat index g*N_CH+c
- clr_all, in, 1, synchronous clear of all pending and any presented interrupt
- irq_ready, in, 1, consumer accepts the presented interrupt
- irq_valid, out, 1, an interrupt is presented
- irq_grp, out, GW, group of the presented interrupt
- irq_chan, out, CW, channel of the presented interrupt
- grp_pend, out, N_GRP, per-group "any enabled pending" flag
REQ-003 There SHALL be one clock; reset SHALL be asynchronous, active-low, on rst_n.

Function
REQ-004 Pending register pend[N_GRP*N_CH] SHALL be updated every cycle. With EDGE=0, pend <= req. With EDGE=1, pend bit sets on req rising edge (req & ~req_q) and clears only on acceptance or clr_all.
REQ-005 With EDGE=1, set SHALL win over clear when a new edge and acceptance of the same bit occur in the same cycle.
REQ-006 A bit SHALL be eligible when pend[g*N_CH+c] & en[c]. grp_pend[g] SHALL be the registered OR of eligible bits in group g, updated one cycle after pend.
REQ-007 Arbitration SHALL use fixed priority: lowest group index wins; within the winning group, highest channel index wins.
REQ-008 The FSM SHALL have states IDLE, PRESENT and RETIRE.
REQ-009 IDLE: if any bit is eligible, the block SHALL latch the winner into irq_grp/irq_chan, assert irq_valid and go to PRESENT.
REQ-010 PRESENT: irq_valid, irq_grp and irq_chan SHALL stay stable regardless of req or en changes until irq_valid & irq_ready, then go to RETIRE.
REQ-011 RETIRE (one cycle): irq_valid SHALL be 0; with EDGE=1 the accepted pend bit SHALL be cleared. The FSM then returns to IDLE.
REQ-012 Latency: a req edge or level sampled at cycle t SHALL give pend at t+1 and irq_valid at t+2 (FSM idle, no higher-priority eligible bit).
REQ-013 irq_ready held high in IDLE SHALL have no effect. Back-to-back service SHALL therefore present at most one interrupt per 3 cycles.
REQ-014 With EDGE=0, acceptance SHALL NOT clear the source. If req stays high, the same interrupt SHALL be re-presented after RETIRE.
REQ-015 clr_all SHALL, the next cycle, clear all pend bits, drop irq_valid and force IDLE. It SHALL take priority over acceptance and new requests in the same cycle. With EDGE=1, req_q is still updated, so no edges are lost or doubled.
REQ-016 Disabling a channel (en=0) SHALL mask it from arbitration and grp_pend but SHALL NOT clear its pend bit. With EDGE=1 the interrupt is served when the channel is re-enabled.

Reset
REQ-017 While rst_n=0, the following SHALL be 0: pend, req_q, grp_pend, irq_valid, irq_grp, irq_chan. The FSM SHALL be in IDLE.
REQ-018 With EDGE=1, a req held high across reset release SHALL count as a rising edge in the first clocked cycle (req_q resets to 0).
REQ-019 Reset asserted mid-PRESENT SHALL drop irq_valid immediately (asynchronously). No interrupt is retired.

Verification
REQ-020 Default parameters, EDGE=1, en=all 1s: one-cycle pulse on req[4] at cycle 0 -> irq_valid=1, irq_grp=0, irq_chan=4 at cycle 2; irq_ready at cycle 5 -> valid=0 at cycle 6, pend[4]=0.
REQ-021 Priority: req[20] (g2,c2), req[13] (g1,c4) and req[10] (g1,c1) rise together -> served in order (1,4), (1,1), (2,2). The presented outputs do not change while new req[26] arrives during PRESENT.
REQ-022 Same-cycle new edge and acceptance on req[3] (EDGE=1) -> pend[3] stays 1 and (0,3) is re-presented after RETIRE.
REQ-023 en[5]=0 with req[5] pulsed -> no irq_valid and grp_pend=0. Setting en[5]=1 -> grp_pend[0]=1 next cycle, then (0,5) is presented.
REQ-024 EDGE=0, req[8] held high -> (0,8) is re-presented every 3 cycles under continuous irq_ready. clr_all during PRESENT -> valid=0 next cycle; re-presented 2 cycles later because the level persists.
REQ-025 rst_n pulsed low during PRESENT -> irq_valid drops without a clock. With EDGE=1 and req[0] held high through release -> (0,0) is presented 2 cycles after the first clock edge.
